// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm blocks: ASCII command bytes,
// receiver and parser state encodings, and a small range helper.
package clock_pkg;

  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_2  = 8'h32;
  localparam logic [7:0] CH_3  = 8'h33;
  localparam logic [7:0] CH_5  = 8'h35;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [2:0] {
    P_IDLE,
    P_H1,
    P_H2,
    P_M1,
    P_M2,
    P_END
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // True when b lies in the inclusive range lo..hi.
  function automatic logic in_range(input logic [7:0] b, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver. The RX line is synchronised, a falling edge starts a
// frame, the start bit is re-checked at half a bit time (glitch rejection),
// then data and stop bits are sampled at mid-bit, LSB first.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       CLK_100M,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);
  import clock_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          sync1_reg, sync2_reg, prev_reg;
  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK_100M or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Receiver state, bit timing counter, shift register and result pulses.
  always_ff @(posedge CLK_100M or posedge rst) begin
    if (rst) begin
      state_reg <= RX_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: every sample point is the last count of its interval.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        if (prev_reg && !sync2_reg) state_next = RX_START;
      end
      RX_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_next = sync2_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {sync2_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          if (sync2_reg) valid_next = 1'b1;
          else           err_next   = 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign data       = shift_reg;
  assign byte_valid = valid_reg;
  assign frame_err  = err_reg;

endmodule

// File: rtl/bt_alarm_ctrl.sv
// Bluetooth alarm controller: receives ASCII commands over UART, holds the
// alarm time, and rings for a fixed number of seconds when the running
// clock reaches hh:mm:00 of the armed alarm.
module bt_alarm_ctrl #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int RING_SECONDS = 60
) (
  input  logic       CLK_100M,
  input  logic       rst,
  input  logic       get,
  input  logic [1:0] hour_high,
  input  logic [3:0] hour_low,
  input  logic [2:0] minute_high,
  input  logic [3:0] minute_low,
  input  logic [2:0] second_high,
  input  logic [3:0] second_low,
  output logic [1:0] alarm_hh,
  output logic [3:0] alarm_hl,
  output logic [2:0] alarm_mh,
  output logic [3:0] alarm_ml,
  output logic       alarm_valid,
  output logic       alarm_ring,
  output logic       cmd_ok,
  output logic       cmd_err
);
  import clock_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int RW = (RING_SECONDS < 2) ? 1 : $clog2(RING_SECONDS + 1);
  localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECONDS);

  logic [7:0]   rx_data;
  logic         byte_valid, frame_err;

  parse_state_t parse_reg, parse_next;
  logic [1:0]   h1_reg;
  logic [3:0]   h2_reg, m2_reg;
  logic [2:0]   m1_reg;
  logic         cap_h1, cap_h2, cap_m1, cap_m2;
  logic         act_load, act_clear, act_silence;
  logic         ok_next, perr;
  logic [7:0]   h2_max;

  logic [1:0]   alarm_hh_reg;
  logic [3:0]   alarm_hl_reg, alarm_ml_reg;
  logic [2:0]   alarm_mh_reg;
  logic         valid_reg, ring_reg, ok_reg, err_reg;
  logic [RW-1:0] cnt_reg;
  logic [3:0]   sec_prev_reg;
  logic         sec_change, match;

  uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK_100M  (CLK_100M),
    .rst       (rst),
    .rx        (get),
    .data      (rx_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // Parser state and the digits captured so far in the current frame.
  always_ff @(posedge CLK_100M or posedge rst) begin
    if (rst) begin
      parse_reg <= P_IDLE;
      h1_reg    <= '0;
      h2_reg    <= '0;
      m1_reg    <= '0;
      m2_reg    <= '0;
    end else begin
      parse_reg <= parse_next;
      // Accepted digits are 0x30..0x39, so subtracting '0' is the low nibble.
      if (cap_h1) h1_reg <= rx_data[1:0];
      if (cap_h2) h2_reg <= rx_data[3:0];
      if (cap_m1) m1_reg <= rx_data[2:0];
      if (cap_m2) m2_reg <= rx_data[3:0];
    end
  end

  // Parser next-state and command actions, evaluated only on a received byte.
  always_comb begin
    parse_next  = parse_reg;
    cap_h1      = 1'b0;
    cap_h2      = 1'b0;
    cap_m1      = 1'b0;
    cap_m2      = 1'b0;
    act_load    = 1'b0;
    act_clear   = 1'b0;
    act_silence = 1'b0;
    ok_next     = 1'b0;
    perr        = 1'b0;
    h2_max      = (h1_reg == 2'd2) ? CH_3 : CH_9;
    if (byte_valid) begin
      case (parse_reg)
        P_IDLE: begin
          if (rx_data == CH_A) begin
            parse_next = P_H1;
          end else if (rx_data == CH_X) begin
            act_clear = 1'b1;
            ok_next   = 1'b1;
          end else if (rx_data == CH_S) begin
            act_silence = 1'b1;
            ok_next     = 1'b1;
          end
        end
        P_H1: begin
          if (in_range(rx_data, CH_0, CH_2)) begin
            cap_h1 = 1'b1; parse_next = P_H2;
          end else perr = 1'b1;
        end
        P_H2: begin
          if (in_range(rx_data, CH_0, h2_max)) begin
            cap_h2 = 1'b1; parse_next = P_M1;
          end else perr = 1'b1;
        end
        P_M1: begin
          if (in_range(rx_data, CH_0, CH_5)) begin
            cap_m1 = 1'b1; parse_next = P_M2;
          end else perr = 1'b1;
        end
        P_M2: begin
          if (in_range(rx_data, CH_0, CH_9)) begin
            cap_m2 = 1'b1; parse_next = P_END;
          end else perr = 1'b1;
        end
        P_END: begin
          if (rx_data == CH_CR || rx_data == CH_LF) begin
            act_load   = 1'b1;
            ok_next    = 1'b1;
            parse_next = P_IDLE;
          end else perr = 1'b1;
        end
        default: parse_next = P_IDLE;
      endcase
      // An unexpected 'A' mid-frame is treated as the start of a new frame.
      if (perr) parse_next = (rx_data == CH_A) ? P_H1 : P_IDLE;
    end
  end

  // Alarm registers and the one-cycle command status pulses.
  always_ff @(posedge CLK_100M or posedge rst) begin
    if (rst) begin
      alarm_hh_reg <= '0;
      alarm_hl_reg <= '0;
      alarm_mh_reg <= '0;
      alarm_ml_reg <= '0;
      valid_reg    <= 1'b0;
      ok_reg       <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      ok_reg  <= ok_next;
      err_reg <= perr | frame_err;
      if (act_load) begin
        alarm_hh_reg <= h1_reg;
        alarm_hl_reg <= h2_reg;
        alarm_mh_reg <= m1_reg;
        alarm_ml_reg <= m2_reg;
        valid_reg    <= 1'b1;
      end else if (act_clear) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign sec_change = (second_low != sec_prev_reg);
  assign match = valid_reg && (hour_high == alarm_hh_reg) && (hour_low == alarm_hl_reg) &&
                 (minute_high == alarm_mh_reg) && (minute_low == alarm_ml_reg) &&
                 (second_high == 3'd0) && (second_low == 4'd0);

  // Ring control: commands win over a match start, which wins over countdown.
  always_ff @(posedge CLK_100M or posedge rst) begin
    if (rst) begin
      sec_prev_reg <= '0;
      ring_reg     <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      sec_prev_reg <= second_low;
      if (act_load || act_clear || act_silence) begin
        ring_reg <= 1'b0;
        cnt_reg  <= '0;
      end else if (sec_change && match && !ring_reg) begin
        ring_reg <= 1'b1;
        cnt_reg  <= RING_LOAD;
      end else if (sec_change && ring_reg) begin
        cnt_reg <= cnt_reg - RW'(1);
        if (cnt_reg == RW'(1)) ring_reg <= 1'b0;
      end
    end
  end

  assign alarm_hh    = alarm_hh_reg;
  assign alarm_hl    = alarm_hl_reg;
  assign alarm_mh    = alarm_mh_reg;
  assign alarm_ml    = alarm_ml_reg;
  assign alarm_valid = valid_reg;
  assign alarm_ring  = ring_reg;
  assign cmd_ok      = ok_reg;
  assign cmd_err     = err_reg;

endmodule
